// File: rtl/spi_tx_serializer_if.sv
// Parallel word handshake between the upstream word source and spi_tx_serializer.
// master: word source (drives s_data/s_valid); slave: the serializer (drives s_ready).
interface spi_tx_serializer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: takes parallel words on a valid/ready handshake and shifts
// each one out MSB-first on sclk/sdata/svalid, sclk being aclk divided by 2*CLK_DIV.
// sdata/svalid only move on sclk falling events, so they are stable at every rising
// edge. At least GAP_CYCLES sclk periods of svalid low separate packets.
// Optional feature macro: SPI_TX_PKT_CNT_EN adds a 16-bit wrapping packet counter
// output pkt_count that steps when svalid falls at the end of a packet.
module spi_tx_serializer #(
  parameter int packet_length = 32,
  parameter int CLK_DIV       = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  spi_tx_serializer_if.slave   s_if,
  output logic                 sclk,
  output logic                 sdata,
  output logic                 svalid,
  output logic                 busy
`ifdef SPI_TX_PKT_CNT_EN
  ,
  output logic [15:0]          pkt_count
`endif
);

  localparam int BW = $clog2(packet_length);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(packet_length - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [DW-1:0]            r_div_cnt;
  logic                     r_sclk;
  logic                     w_div_wrap;
  logic                     w_fall;

  logic [packet_length-1:0] r_shift;
  logic [BW-1:0]            r_bit_cnt;
  logic [GW-1:0]            r_gap_cnt;
  logic                     r_sdata;
  logic                     r_svalid;
  logic                     r_s_ready;
  logic                     r_busy;

  logic                     w_load;
  logic                     w_start;
  logic                     w_shift;
  logic                     w_end;
  logic                     w_gap_inc;

  assign w_div_wrap = (r_div_cnt == LAST_DIV);
  // A fall event is the cycle whose edge takes sclk from 1 to 0.
  assign w_fall     = w_div_wrap && r_sclk;

  // Free-running sclk divider: toggle sclk every CLK_DIV aclk cycles.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and per-cycle action strobes; everything outside IDLE waits on fall events.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_end       = 1'b0;
    w_gap_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_if.s_valid && r_s_ready) begin
          w_state_nxt = ARM;
          w_load      = 1'b1;
        end
      end
      ARM: begin
        if (w_fall) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        if (w_fall) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = GAP;
            w_end       = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_fall) begin
          if (r_gap_cnt == LAST_GAP) begin
            w_state_nxt = IDLE;
          end else begin
            w_gap_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered control outputs and counters; s_ready/busy are derived from the next state
  // so they line up with the state register without any path from s_valid.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sdata   <= 1'b0;
      r_svalid  <= 1'b0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      if (w_load) begin
        r_bit_cnt <= '0;
      end
      if (w_start) begin
        r_svalid <= 1'b1;
        r_sdata  <= r_shift[packet_length-1];
      end
      if (w_shift) begin
        r_sdata   <= r_shift[packet_length-2];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_end) begin
        r_svalid  <= 1'b0;
        r_sdata   <= 1'b0;
        r_gap_cnt <= '0;
      end
      if (w_gap_inc) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end

  // Word shift register: captured only at the handshake, so later s_data changes are ignored.
  always_ff @(posedge aclk) begin
    if (w_load) begin
      r_shift <= s_if.s_data;
    end else if (w_shift) begin
      r_shift <= {r_shift[packet_length-2:0], 1'b0};
    end
  end

`ifdef SPI_TX_PKT_CNT_EN
  logic [15:0] r_pkt_count;

  // Completed-packet counter, stepping on the same edge that drops svalid.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pkt_count <= '0;
    end else if (w_end) begin
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign pkt_count = r_pkt_count;
`endif

  assign s_if.s_ready = r_s_ready;
  assign sclk         = r_sclk;
  assign sdata        = r_sdata;
  assign svalid       = r_svalid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Directed bench for spi_tx_serializer (packet_length=32, CLK_DIV=2, GAP_CYCLES=4).
// A serial receiver samples sdata at each sclk rise while svalid is high and
// rebuilds words, bit counts and inter-packet gaps for comparison with expected values.
module tb_spi_tx_serializer;

  localparam int PL  = 32;
  localparam int CD  = 2;
  localparam int GC  = 4;

  logic aclk;
  logic aresetn;
  logic sclk;
  logic sdata;
  logic svalid;
  logic busy;
`ifdef SPI_TX_PKT_CNT_EN
  logic [15:0] pkt_count;
`endif

  spi_tx_serializer_if #(.DATA_W(PL)) s_if ();

  spi_tx_serializer #(
    .packet_length (PL),
    .CLK_DIV       (CD),
    .GAP_CYCLES    (GC)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_if      (s_if),
    .sclk      (sclk),
    .sdata     (sdata),
    .svalid    (svalid),
    .busy      (busy)
`ifdef SPI_TX_PKT_CNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Receiver model state
  logic [31:0] rx_q[$];
  int          rxn_q[$];
  logic [31:0] mon_word;
  int          mon_bits  = 0;
  int          low_rises = 0;
  int          last_gap  = 0;
  bit          have_prev = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_svalid = 1'b0;
  int          falls = 0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      mon_bits    = 0;
      low_rises   = 0;
      have_prev   = 0;
      prev_sclk   = 1'b0;
      prev_svalid = 1'b0;
      falls       = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        if (svalid) begin
          if (mon_bits == 0 && have_prev) last_gap = low_rises;
          mon_word = {mon_word[30:0], sdata};
          mon_bits++;
        end else begin
          if (mon_bits != 0) begin
            rx_q.push_back(mon_word);
            rxn_q.push_back(mon_bits);
            mon_bits  = 0;
            have_prev = 1;
            low_rises = 0;
          end
          low_rises++;
        end
      end
      if (prev_svalid && !svalid) begin
        falls++;
`ifdef SPI_TX_PKT_CNT_EN
        check_eq("pkt_count_at_fall", {16'd0, pkt_count}, falls);
`endif
      end
      prev_sclk   = sclk;
      prev_svalid = svalid;
    end
  end

  task automatic send(input logic [31:0] w);
    int t;
    s_if.s_data  = w;
    s_if.s_valid = 1'b1;
    t = 0;
    while (!s_if.s_ready && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    check_eq("send_ready", {31'd0, s_if.s_ready}, 32'd1);
    @(negedge aclk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check_eq("rx_count", rx_q.size(), n);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rxn_q.delete();
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
    if (idx < rx_q.size()) begin
      check_eq(tag, rx_q[idx], exp);
      check_eq({tag, "_bits"}, rxn_q[idx], 32);
    end
  endtask

  initial begin
    int t;
    aresetn      = 1'b0;
    s_if.s_data  = '0;
    s_if.s_valid = 1'b0;

    // Reset held 5 cycles
    repeat (5) @(negedge aclk);
    check_eq("rst_sclk",   {31'd0, sclk},         32'd0);
    check_eq("rst_svalid", {31'd0, svalid},       32'd0);
    check_eq("rst_sdata",  {31'd0, sdata},        32'd0);
    check_eq("rst_ready",  {31'd0, s_if.s_ready}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy},         32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("ready_after_rst", {31'd0, s_if.s_ready}, 32'd1);
    check_eq("idle_svalid",     {31'd0, svalid},       32'd0);

    // Single word
    clear_rx();
    send(32'hA5A50F0F);
    check_eq("busy_after_hs", {31'd0, busy}, 32'd1);
    wait_rx(1);
    check_word("single", 0, 32'hA5A50F0F);

    // Back-to-back with s_valid held
    repeat (40) @(negedge aclk);
    clear_rx();
    send(32'hFFFFFFFF);
    send(32'h00000001);
    wait_rx(2);
    check_word("b2b_0", 0, 32'hFFFFFFFF);
    check_word("b2b_1", 1, 32'h00000001);
    check_eq("b2b_gap_ok", {31'd0, (last_gap >= GC)}, 32'd1);

    // s_data changed mid-packet
    repeat (40) @(negedge aclk);
    clear_rx();
    send(32'h0000FFFF);
    repeat (40) @(negedge aclk);
    s_if.s_data = 32'hDEADBEEF;
    wait_rx(1);
    check_word("hold_data", 0, 32'h0000FFFF);

    // Reset after 10 bits
    repeat (40) @(negedge aclk);
    clear_rx();
    send(32'hCAFEF00D);
    t = 0;
    while (mon_bits < 10 && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    check_eq("mid_bits", mon_bits, 10);
    aresetn = 1'b0;
    @(negedge aclk);
    check_eq("mid_rst_svalid", {31'd0, svalid},       32'd0);
    check_eq("mid_rst_sdata",  {31'd0, sdata},        32'd0);
    check_eq("mid_rst_sclk",   {31'd0, sclk},         32'd0);
    check_eq("mid_rst_busy",   {31'd0, busy},         32'd0);
    check_eq("mid_rst_ready",  {31'd0, s_if.s_ready}, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    clear_rx();
    send(32'h12345678);
    wait_rx(1);
    check_word("after_rst", 0, 32'h12345678);

`ifdef SPI_TX_PKT_CNT_EN
    // Packet counter after reset: one packet so far, then two more
    repeat (40) @(negedge aclk);
    clear_rx();
    send(32'h11111111);
    send(32'h22222222);
    wait_rx(2);
    repeat (4) @(negedge aclk);
    check_eq("pkt_count_3", {16'd0, pkt_count}, 32'd3);
    check_word("cnt_1", 0, 32'h11111111);
    check_word("cnt_2", 1, 32'h22222222);
`endif

    repeat (20) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
